// File: rtl/collision_scanner_pkg.sv
// rtl/collision_scanner_pkg.sv - shared types and defaults for the collision scanner
package collision_scanner_pkg;

    localparam int POSITION_REG_MAX_DEF = 11;
    localparam int NUM_OBJ_DEF          = 8;
    localparam int HIT_CNT_W            = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/collision_scanner_if.sv
// rtl/collision_scanner_if.sv - box-table write port, scan control and hit stream
interface collision_scanner_if
    import collision_scanner_pkg::*;
#(
    parameter int POSITION_REG_MAX = POSITION_REG_MAX_DEF,
    parameter int NUM_OBJ          = NUM_OBJ_DEF
);
    localparam int IW = $clog2(NUM_OBJ);
    localparam int CW = POSITION_REG_MAX + 1;

    logic                 wr_en;
    logic [IW-1:0]        wr_idx;
    logic [CW-1:0]        wr_x1;
    logic [CW-1:0]        wr_y1;
    logic [CW-1:0]        wr_x2;
    logic [CW-1:0]        wr_y2;
    logic                 wr_active;
    logic                 start;
    logic                 hit_ready;
    logic                 hit_valid;
    logic [IW-1:0]        hit_a;
    logic [IW-1:0]        hit_b;
    logic                 busy;
    logic                 done;
    logic [HIT_CNT_W-1:0] hit_count;

    modport master (
        output wr_en, wr_idx, wr_x1, wr_y1, wr_x2, wr_y2, wr_active, start, hit_ready,
        input  hit_valid, hit_a, hit_b, busy, done, hit_count
    );

    modport slave (
        input  wr_en, wr_idx, wr_x1, wr_y1, wr_x2, wr_y2, wr_active, start, hit_ready,
        output hit_valid, hit_a, hit_b, busy, done, hit_count
    );

endinterface

// File: rtl/collision_scanner_box_overlap_cmp.sv
// rtl/collision_scanner_box_overlap_cmp.sv - combinational strict box overlap test
module box_overlap_cmp
    import collision_scanner_pkg::*;
#(
    parameter int CW = POSITION_REG_MAX_DEF + 1
) (
    input  logic [CW-1:0] a_x1,
    input  logic [CW-1:0] a_y1,
    input  logic [CW-1:0] a_x2,
    input  logic [CW-1:0] a_y2,
    input  logic [CW-1:0] b_x1,
    input  logic [CW-1:0] b_y1,
    input  logic [CW-1:0] b_x2,
    input  logic [CW-1:0] b_y2,
    output logic          overlap
);

    // Strict compares: shared edges and degenerate boxes never count as overlap.
    always_comb begin
        overlap = (a_x1 < b_x2) && (a_x2 > b_x1) && (a_y1 < b_y2) && (a_y2 > b_y1);
    end

endmodule

// File: rtl/collision_scanner.sv
// rtl/collision_scanner.sv - box table plus pairwise overlap scan emitting colliding pairs
module collision_scanner
    import collision_scanner_pkg::*;
#(
    parameter int POSITION_REG_MAX = POSITION_REG_MAX_DEF,
    parameter int NUM_OBJ          = NUM_OBJ_DEF
) (
    input logic                clk,
    input logic                rst_n,
    collision_scanner_if.slave bus
);

    localparam int IW = $clog2(NUM_OBJ);
    localparam int CW = POSITION_REG_MAX + 1;
    localparam logic [IW-1:0] LAST_I = IW'(NUM_OBJ - 2);
    localparam logic [IW-1:0] LAST_J = IW'(NUM_OBJ - 1);

    state_e               state_q, state_d;
    logic [IW-1:0]        i_q, i_d, j_q, j_d;
    logic [IW-1:0]        i_nx, j_nx;
    logic [NUM_OBJ-1:0]   active_q, active_d;
    logic [CW-1:0]        x1_q [NUM_OBJ];
    logic [CW-1:0]        y1_q [NUM_OBJ];
    logic [CW-1:0]        x2_q [NUM_OBJ];
    logic [CW-1:0]        y2_q [NUM_OBJ];
    logic [CW-1:0]        x1_d [NUM_OBJ];
    logic [CW-1:0]        y1_d [NUM_OBJ];
    logic [CW-1:0]        x2_d [NUM_OBJ];
    logic [CW-1:0]        y2_d [NUM_OBJ];
    logic                 hit_valid_q, hit_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [IW-1:0]        hit_a_q, hit_a_d, hit_b_q, hit_b_d;
    logic [HIT_CNT_W-1:0] hit_count_q, hit_count_d;
    logic                 wr_fire, overlap, pair_hit, last_pair;

    box_overlap_cmp #(.CW(CW)) u_cmp (
        .a_x1    (x1_q[i_q]),
        .a_y1    (y1_q[i_q]),
        .a_x2    (x2_q[i_q]),
        .a_y2    (y2_q[i_q]),
        .b_x1    (x1_q[j_q]),
        .b_y1    (y1_q[j_q]),
        .b_x2    (x2_q[j_q]),
        .b_y2    (y2_q[j_q]),
        .overlap (overlap)
    );

    // The table is frozen while a scan walks it; writes land only in IDLE or DONE.
    always_comb begin
        wr_fire  = bus.wr_en && ((state_q == IDLE) || (state_q == DONE))
                   && (int'(bus.wr_idx) < NUM_OBJ);
        active_d = active_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        x2_d     = x2_q;
        y2_d     = y2_q;
        if (wr_fire) begin
            active_d[bus.wr_idx] = bus.wr_active;
            x1_d[bus.wr_idx]     = bus.wr_x1;
            y1_d[bus.wr_idx]     = bus.wr_y1;
            x2_d[bus.wr_idx]     = bus.wr_x2;
            y2_d[bus.wr_idx]     = bus.wr_y2;
        end
    end

    always_comb begin
        pair_hit  = active_q[i_q] && active_q[j_q] && overlap;
        last_pair = (i_q == LAST_I) && (j_q == LAST_J);
        if (j_q == LAST_J) begin
            i_nx = i_q + IW'(1);
            j_nx = i_q + IW'(2);
        end else begin
            i_nx = i_q;
            j_nx = j_q + IW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        hit_a_d     = hit_a_q;
        hit_b_d     = hit_b_q;
        hit_count_d = hit_count_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = SCAN;
                    i_d         = '0;
                    j_d         = IW'(1);
                    hit_count_d = '0;
                end
            end
            SCAN: begin
                if (pair_hit) begin
                    state_d = EMIT;
                    hit_a_d = i_q;
                    hit_b_d = j_q;
                end else if (last_pair) begin
                    state_d = DONE;
                end else begin
                    i_d = i_nx;
                    j_d = j_nx;
                end
            end
            EMIT: begin
                if (bus.hit_ready) begin
                    if (hit_count_q != '1) begin
                        hit_count_d = hit_count_q + HIT_CNT_W'(1);
                    end
                    if (last_pair) begin
                        state_d = DONE;
                    end else begin
                        state_d = SCAN;
                        i_d     = i_nx;
                        j_d     = j_nx;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Status outputs are registered copies of the next-state decode.
        hit_valid_d = (state_d == EMIT);
        busy_d      = (state_d == SCAN) || (state_d == EMIT);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            i_q         <= '0;
            j_q         <= IW'(1);
            active_q    <= '0;
            hit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hit_a_q     <= '0;
            hit_b_q     <= '0;
            hit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            active_q    <= active_d;
            hit_valid_q <= hit_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            hit_a_q     <= hit_a_d;
            hit_b_q     <= hit_b_d;
            hit_count_q <= hit_count_d;
        end
    end

    always_ff @(posedge clk) begin
        x1_q <= x1_d;
        y1_q <= y1_d;
        x2_q <= x2_d;
        y2_q <= y2_d;
    end

    assign bus.hit_valid = hit_valid_q;
    assign bus.hit_a     = hit_a_q;
    assign bus.hit_b     = hit_b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.hit_count = hit_count_q;

endmodule

// File: tb/tb_collision_scanner.sv
// tb/tb_collision_scanner.sv - directed table-driven bench for collision_scanner
module tb_collision_scanner;
    import collision_scanner_pkg::*;

    localparam int PM = 11;
    localparam int NO = 8;

    typedef struct {
        int ax1, ay1, ax2, ay2;
        int bx1, by1, bx2, by2;
        bit act_a, act_b;
        int exp_hits;
    } vec_t;

    typedef struct {
        int a;
        int b;
    } pair_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    pair_t hits[$];
    int   latency;
    int   pw_idx, pw_x1, pw_y1, pw_x2, pw_y2;
    bit   pw_act;
    vec_t vecs[12];

    collision_scanner_if #(.POSITION_REG_MAX(PM), .NUM_OBJ(NO)) bus ();

    collision_scanner #(.POSITION_REG_MAX(PM), .NUM_OBJ(NO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_wr(input int idx, input int x1, input int y1, input int x2,
                            input int y2, input bit act);
        bus.wr_en     = 1'b1;
        bus.wr_idx    = 3'(idx);
        bus.wr_x1     = 12'(x1);
        bus.wr_y1     = 12'(y1);
        bus.wr_x2     = 12'(x2);
        bus.wr_y2     = 12'(y2);
        bus.wr_active = act;
    endtask

    task automatic write_entry(input int idx, input int x1, input int y1, input int x2,
                               input int y2, input bit act);
        drive_wr(idx, x1, y1, x2, y2, act);
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    // Starts a scan at the current negedge and follows it to done; stall holds off each
    // hit for that many cycles, mid_k issues the pending write k cycles after start.
    task automatic run_scan(input int stall, input bit wr_with_start, input int mid_k);
        int  wait_cnt;
        bit  seen;
        int  cur_a, cur_b;
        seen     = 1'b0;
        wait_cnt = 0;
        cur_a    = 0;
        cur_b    = 0;
        latency  = -1;
        hits.delete();
        bus.start     = 1'b1;
        bus.hit_ready = (stall == 0);
        if (wr_with_start) drive_wr(pw_idx, pw_x1, pw_y1, pw_x2, pw_y2, pw_act);
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k == 1) chk("busy_after_start", int'(bus.busy), 1);
            if (bus.done) begin
                latency = k;
                break;
            end
            if (bus.hit_valid) begin
                if (!seen) begin
                    seen     = 1'b1;
                    wait_cnt = 0;
                    cur_a    = int'(bus.hit_a);
                    cur_b    = int'(bus.hit_b);
                    hits.push_back('{cur_a, cur_b});
                end else begin
                    chk("hit_a_stable", int'(bus.hit_a), cur_a);
                    chk("hit_b_stable", int'(bus.hit_b), cur_b);
                end
                if (wait_cnt < stall) begin
                    bus.hit_ready = 1'b0;
                    wait_cnt++;
                end else begin
                    bus.hit_ready = 1'b1;
                    seen          = 1'b0;
                end
            end else begin
                bus.hit_ready = (stall == 0);
            end
            if (k == mid_k) drive_wr(pw_idx, pw_x1, pw_y1, pw_x2, pw_y2, pw_act);
            else            bus.wr_en = 1'b0;
        end
        bus.wr_en     = 1'b0;
        bus.hit_ready = 1'b1;
        if (latency < 0) begin
            errors++;
            checks++;
            $display("FAIL scan_timeout: got no done expected done within 300 cycles");
        end
        @(negedge clk);
        chk("done_one_cycle", int'(bus.done), 0);
    endtask

    task automatic set_pw(input int idx, input int x1, input int y1, input int x2,
                          input int y2, input bit act);
        pw_idx = idx; pw_x1 = x1; pw_y1 = y1; pw_x2 = x2; pw_y2 = y2; pw_act = act;
    endtask

    initial begin
        vecs[0]  = '{10, 10, 20, 20, 15, 15, 30, 30, 1, 1, 1};
        vecs[1]  = '{10, 10, 20, 20, 20, 10, 30, 20, 1, 1, 0};
        vecs[2]  = '{10, 10, 20, 20, 10, 20, 20, 30, 1, 1, 0};
        vecs[3]  = '{10, 10, 20, 20, 12, 12, 14, 14, 1, 1, 1};
        vecs[4]  = '{5, 5, 5, 9, 5, 5, 5, 9, 1, 1, 0};
        vecs[5]  = '{20, 20, 10, 10, 20, 20, 10, 10, 1, 1, 0};
        vecs[6]  = '{0, 0, 4095, 4095, 4094, 4094, 4095, 4095, 1, 1, 1};
        vecs[7]  = '{0, 0, 5, 5, 100, 100, 200, 200, 1, 1, 0};
        vecs[8]  = '{10, 10, 20, 20, 15, 15, 30, 30, 1, 0, 0};
        vecs[9]  = '{10, 10, 21, 20, 20, 10, 30, 20, 1, 1, 1};
        vecs[10] = '{100, 0, 2100, 10, 2000, 0, 3000, 10, 1, 1, 1};
        vecs[11] = '{10, 10, 20, 20, 15, 15, 30, 30, 0, 1, 0};

        rst_n = 1'b0;
        bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_x1 = '0; bus.wr_y1 = '0;
        bus.wr_x2 = '0; bus.wr_y2 = '0; bus.wr_active = 1'b0;
        bus.start = 1'b0; bus.hit_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_hit_valid", int'(bus.hit_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_hit_a", int'(bus.hit_a), 0);
        chk("rst_hit_b", int'(bus.hit_b), 0);
        chk("rst_hit_count", int'(bus.hit_count), 0);

        for (int v = 0; v < 12; v++) begin
            write_entry(0, vecs[v].ax1, vecs[v].ay1, vecs[v].ax2, vecs[v].ay2, vecs[v].act_a);
            write_entry(1, vecs[v].bx1, vecs[v].by1, vecs[v].bx2, vecs[v].by2, vecs[v].act_b);
            run_scan(0, 1'b0, -1);
            chk($sformatf("vec%0d_hit_count", v), int'(bus.hit_count), vecs[v].exp_hits);
            chk($sformatf("vec%0d_hits", v), hits.size(), vecs[v].exp_hits);
            chk($sformatf("vec%0d_latency", v), latency, 29 + vecs[v].exp_hits);
            if (vecs[v].exp_hits == 1 && hits.size() == 1) begin
                chk($sformatf("vec%0d_pair_a", v), hits[0].a, 0);
                chk($sformatf("vec%0d_pair_b", v), hits[0].b, 1);
            end
        end

        // Single hit between entries 0 and 3.
        write_entry(0, 10, 10, 20, 20, 1'b1);
        write_entry(1, 0, 0, 0, 0, 1'b0);
        write_entry(3, 15, 15, 30, 30, 1'b1);
        run_scan(0, 1'b0, -1);
        chk("one_hit_count", int'(bus.hit_count), 1);
        chk("one_hit_latency", latency, 30);
        if (hits.size() == 1) begin
            chk("one_hit_a", hits[0].a, 0);
            chk("one_hit_b", hits[0].b, 3);
        end else chk("one_hit_n", hits.size(), 1);

        // Touching edges.
        write_entry(3, 0, 0, 0, 0, 1'b0);
        write_entry(1, 20, 10, 30, 20, 1'b1);
        run_scan(0, 1'b0, -1);
        chk("touch_count", int'(bus.hit_count), 0);
        chk("touch_latency", latency, 29);

        // Three identical boxes with back-pressure.
        write_entry(0, 0, 0, 8, 8, 1'b1);
        write_entry(1, 0, 0, 8, 8, 1'b1);
        write_entry(2, 0, 0, 8, 8, 1'b1);
        run_scan(5, 1'b0, -1);
        chk("stall_count", int'(bus.hit_count), 3);
        chk("stall_latency", latency, 28 + 3 * 6 + 1);
        chk("stall_nhits", hits.size(), 3);
        if (hits.size() == 3) begin
            chk("stall_h0", hits[0].a * 16 + hits[0].b, 16 * 0 + 1);
            chk("stall_h1", hits[1].a * 16 + hits[1].b, 16 * 0 + 2);
            chk("stall_h2", hits[2].a * 16 + hits[2].b, 16 * 1 + 2);
        end
        chk("count_held_idle", int'(bus.hit_count), 3);

        // Writes during a scan are dropped; writes in IDLE or with start are kept.
        write_entry(0, 0, 0, 1, 1, 1'b1);
        write_entry(1, 5, 5, 6, 6, 1'b1);
        write_entry(2, 0, 0, 0, 0, 1'b0);
        set_pw(1, 0, 0, 1, 1, 1'b1);
        run_scan(0, 1'b0, 3);
        chk("midwr_scan_count", int'(bus.hit_count), 0);
        run_scan(0, 1'b0, -1);
        chk("midwr_ignored_count", int'(bus.hit_count), 0);
        write_entry(1, 0, 0, 1, 1, 1'b1);
        run_scan(0, 1'b0, -1);
        chk("idle_wr_count", int'(bus.hit_count), 1);
        set_pw(1, 5, 5, 6, 6, 1'b1);
        run_scan(0, 1'b1, -1);
        chk("start_wr_count", int'(bus.hit_count), 0);

        // Full table, every pair collides.
        for (int e = 0; e < NO; e++) write_entry(e, 0, 0, 8, 8, 1'b1);
        run_scan(0, 1'b0, -1);
        chk("full_count", int'(bus.hit_count), 28);
        chk("full_latency", latency, 57);
        chk("full_nhits", hits.size(), 28);
        if (hits.size() == 28) begin
            int n;
            n = 0;
            for (int a = 0; a < NO; a++)
                for (int b = a + 1; b < NO; b++) begin
                    if (hits[n].a != a || hits[n].b != b) begin
                        chk($sformatf("full_order%0d", n), hits[n].a * 16 + hits[n].b, a * 16 + b);
                    end
                    n++;
                end
            chk("full_order_walked", n, 28);
        end

        // Reset while a hit is pending.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.hit_ready = 1'b0;
        for (int k = 0; k < 20 && !bus.hit_valid; k++) @(negedge clk);
        chk("pre_reset_emit", int'(bus.hit_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_hit_valid", int'(bus.hit_valid), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_hit_count", int'(bus.hit_count), 0);
        chk("arst_hit_ab", int'(bus.hit_a) + int'(bus.hit_b), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("arst_no_done", int'(bus.done), 0);
        end
        bus.hit_ready = 1'b1;
        rst_n = 1'b1;
        run_scan(0, 1'b0, -1);
        chk("post_rst_count", int'(bus.hit_count), 0);
        chk("post_rst_latency", latency, 29);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/collision_scanner.md
COLLISION_SCANNER -- requirements
Module: collision_scanner

Interface
REQ-001 Parameter POSITION_REG_MAX, default 11, is the MSB index of every coordinate (coordinate width = POSITION_REG_MAX+1).
REQ-002 Parameter NUM_OBJ, default 8, is the box-table depth; legal range 2..16; IW = $clog2(NUM_OBJ).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 wr_en  input  1  box-table write strobe.
REQ-006 wr_idx  input  IW  table entry written.
REQ-007 wr_x1, wr_y1, wr_x2, wr_y2  input  POSITION_REG_MAX+1 each  box corners, with (x1,y1) as the top-left corner.
REQ-008 wr_active  input  1  entry participates in scans when 1.
REQ-009 start  input  1  one-cycle scan request.
REQ-010 hit_ready  input  1  consumer accepts the current hit.
REQ-011 hit_valid  output  1  a colliding pair is presented.
REQ-012 hit_a, hit_b  output  IW each  indices of the colliding pair, with hit_a < hit_b.
REQ-013 busy  output  1  scan in progress (states SCAN or EMIT).
REQ-014 done  output  1  one-cycle pulse at scan completion.
REQ-015 hit_count  output  8  hits in the current or last scan; saturates at 255.

Function
REQ-016 The overlap test is strict: overlap = (a.x1 < b.x2) && (a.x2 > b.x1) && (a.y1 < b.y2) && (a.y2 > b.y1), using unsigned compares.
  - Touching edges do not overlap.
  - Zero- or negative-area boxes do not overlap.
REQ-017 The FSM has four states: IDLE, SCAN, EMIT, DONE.
REQ-018 In IDLE, a start pulse moves the FSM to SCAN, sets i=0 and j=1, and clears hit_count.
  - start is ignored in every other state.
REQ-019 SCAN evaluates pair (i,j) in one cycle.
  - If both entries are active and overlap, the FSM goes to EMIT.
  - Otherwise the pair index advances.
REQ-020 Pair order is i ascending and, within each i, j ascending from i+1.
  - After the last pair (NUM_OBJ-2, NUM_OBJ-1), the FSM goes to DONE.
REQ-021 In EMIT, hit_valid=1 with hit_a=i and hit_b=j.
  - hit_a and hit_b stay stable until a cycle with hit_valid && hit_ready.
  - On that cycle, hit_count increments (saturating at 255), the pair index advances, and the FSM returns to SCAN, or goes to DONE after the last pair.
REQ-022 hit_valid does not depend combinationally on hit_ready; hit_ready held high gives one hit every 2 cycles.
REQ-023 DONE asserts done for exactly one cycle, then the FSM goes to IDLE.
REQ-024 With no hits, the start-to-done latency is NUM_OBJ*(NUM_OBJ-1)/2 + 1 cycles (done is high on the cycle after the last SCAN).
REQ-025 Table writes are accepted in IDLE and DONE and ignored while busy=1.
  - A write in the same cycle as an accepted start commits first and is visible to the scan.
REQ-026 Inactive entries produce no hits but are still walked; the walk order and latency are unchanged.
REQ-027 hit_count holds its value after DONE until the next accepted start.

Reset
REQ-028 rst_n low asynchronously forces:
  - state=IDLE;
  - i=0, j=1;
  - hit_valid=0, busy=0, done=0;
  - hit_a=0, hit_b=0, hit_count=0;
  - all wr_active bits=0.
  Coordinate storage need not be reset.
REQ-029 Reset during SCAN or EMIT abandons the scan with no done pulse; a pending hit is dropped.
REQ-030 The first start is honoured on the first cycle after rst_n deasserts.

Structure
REQ-031 A shared package holds:
  - the state enum (IDLE, SCAN, EMIT, DONE);
  - the POSITION_REG_MAX default;
  - the NUM_OBJ default;
  - the hit_count width (8).
REQ-032 One sub-module, box_overlap_cmp, is purely combinational; it takes two boxes and returns the overlap bit of REQ-016.
REQ-033 The top level contains the table registers, the pair-index counters, the FSM and the output registers.

Verification
REQ-034 Box 0=(10,10,20,20), box 3=(15,15,30,30), all other boxes inactive, start with hit_ready=1 -> one hit (0,3); hit_count=1; done on cycle 30 after start.
REQ-035 Box 0=(10,10,20,20), box 1=(20,10,30,20), edges touching -> no hit; hit_count=0; done after 29 cycles.
REQ-036 Boxes 0, 1 and 2 all equal (0,0,8,8), with hit_ready=0 for 5 cycles on each hit -> hits (0,1), (0,2), (1,2) in that order; hit_a and hit_b stable while stalled; hit_count=3.
REQ-037 A write to entry 1 during SCAN -> table unchanged; the write issued after done takes effect in the next scan.
REQ-038 rst_n pulsed low while in EMIT -> outputs at reset values immediately; no done pulse; a new start gives a fresh scan with all entries inactive and zero hits.
REQ-039 All 8 entries active and identical -> 28 hits in pair order; hit_count=28; with hit_ready=1 the scan takes 28*2 + 0 + 1 cycles.
